// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustive stimulus engine for an N-input gate under test.
// Drives every input vector, waits SETTLE cycles, compares dut_o against the
// reference function selected by FUNC, and reports the mismatch count, the
// first failing vector and a pass flag.
// Optional build macro: GATE_SWEEP_GRAY_EN selects Gray-coded vector order
// (vec(i) = i ^ (i >> 1)); left undefined, vectors run in binary order.
// Legal parameters: N 1..16, SETTLE 1..255, FUNC 0..5
// (0 NAND, 1 AND, 2 NOR, 3 OR, 4 XOR, 5 XNOR).
module gate_sweep_checker #(
  parameter int N      = 5,
  parameter int SETTLE = 2,
  parameter int FUNC   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] stim,
  input  logic         dut_o,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic [N-1:0] first_fail,
  output logic         first_fail_vld
);

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_idx;
  logic [7:0]   r_cnt;
  logic [N-1:0] r_stim;
  logic         r_busy;
  logic         r_done;
  logic         r_pass;
  logic [N:0]   r_err_cnt;
  logic [N-1:0] r_first_fail;
  logic         r_first_fail_vld;

  logic         w_accept;
  logic         w_check;
  logic         w_last;
  logic         w_ref;
  logic         w_mismatch;
  logic [N-1:0] w_idx_nxt;
  logic [N:0]   w_err_inc;

  // Maps a sweep index onto the vector actually driven to the gate.
  function automatic logic [N-1:0] vec(input logic [N-1:0] i);
`ifdef GATE_SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  assign w_accept   = (r_state == IDLE) && start;
  assign w_check    = (r_state == CHECK);
  assign w_last     = &r_idx;
  assign w_idx_nxt  = r_idx + 1'b1;
  assign w_mismatch = dut_o ^ w_ref;
  assign w_err_inc  = r_err_cnt + {{N{1'b0}}, w_mismatch};

  // Reference gate output for the vector currently on stim.
  always_comb begin
    // NOTE: default first so every path assigns w_ref and no latch is inferred.
    w_ref = 1'b0;
    case (FUNC)
      0:       w_ref = ~(&r_stim);
      1:       w_ref = &r_stim;
      2:       w_ref = ~(|r_stim);
      3:       w_ref = |r_stim;
      4:       w_ref = ^r_stim;
      5:       w_ref = ~(^r_stim);
      default: w_ref = ~(&r_stim);
    endcase
  end

  // Next-state logic: hold in APPLY until the settle counter reaches 1.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = APPLY;
      APPLY:   if (r_cnt == 8'd1) w_state_nxt = CHECK;
      CHECK:   w_state_nxt = w_last ? IDLE : APPLY;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Sweep datapath: vector/index stepping, settle timer and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx            <= '0;
      r_cnt            <= '0;
      r_stim           <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_cnt        <= '0;
      r_first_fail     <= '0;
      r_first_fail_vld <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_err_cnt        <= '0;
        r_pass           <= 1'b0;
        r_first_fail     <= '0;
        r_first_fail_vld <= 1'b0;
        r_idx            <= '0;
        r_stim           <= vec('0);
        r_cnt            <= SETTLE_CNT;
        r_busy           <= 1'b1;
      end else if (r_state == APPLY) begin
        if (r_cnt != 8'd1) r_cnt <= r_cnt - 8'd1;
      end else if (w_check) begin
        r_err_cnt <= w_err_inc;
        if (w_mismatch && !r_first_fail_vld) begin
          r_first_fail     <= r_stim;
          r_first_fail_vld <= 1'b1;
        end
        if (w_last) begin
          // Final vector: stim holds, pass includes this check's result.
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_pass <= (w_err_inc == '0);
        end else begin
          r_idx  <= w_idx_nxt;
          r_stim <= vec(w_idx_nxt);
          r_cnt  <= SETTLE_CNT;
        end
      end
    end
  end

  assign stim           = r_stim;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err_cnt;
  assign first_fail     = r_first_fail;
  assign first_fail_vld = r_first_fail_vld;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: several instances covering every FUNC and a
// spread of N/SETTLE values. Each gate model is the ideal reference function
// XOR a per-vector fault table, so expected results follow from the table.
module tb_gate_sweep_checker;

  localparam int NI = 6;
  localparam int P_N [NI] = '{2, 3, 5, 1, 4, 3};
  localparam int P_S [NI] = '{1, 2, 3, 1, 1, 4};
  localparam int P_F [NI] = '{0, 2, 4, 5, 1, 3};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v [NI];
  bit          flip [0:31];

  logic [15:0] g_stim [NI];
  logic [15:0] g_ff   [NI];
  logic [16:0] g_err  [NI];
  logic        g_busy [NI];
  logic        g_done [NI];
  logic        g_pass [NI];
  logic        g_ffv  [NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Ideal gate output from the count of ones in the input vector.
  function automatic bit ref_fn(input int func, input int n, input int v);
    int pop;
    pop = $countones(v);
    case (func)
      0:       return pop != n;
      1:       return pop == n;
      2:       return pop == 0;
      3:       return pop != 0;
      4:       return (pop % 2) == 1;
      default: return (pop % 2) == 0;
    endcase
  endfunction

  // Vector driven at sweep position i.
  function automatic int vec_of(input int i);
`ifdef GATE_SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GN = P_N[g];
    logic [GN-1:0] stim;
    logic [GN-1:0] first_fail;
    logic [GN:0]   err_cnt;
    logic          busy, done, pass, first_fail_vld, dut_o;

    always_comb dut_o = ref_fn(P_F[g], GN, int'(stim)) ^ flip[int'(stim)];

    gate_sweep_checker #(.N(GN), .SETTLE(P_S[g]), .FUNC(P_F[g])) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start_v[g]),
      .stim           (stim),
      .dut_o          (dut_o),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_cnt        (err_cnt),
      .first_fail     (first_fail),
      .first_fail_vld (first_fail_vld)
    );

    assign g_stim[g] = 16'(stim);
    assign g_ff[g]   = 16'(first_fail);
    assign g_err[g]  = 17'(err_cnt);
    assign g_busy[g] = busy;
    assign g_done[g] = done;
    assign g_pass[g] = pass;
    assign g_ffv[g]  = first_fail_vld;
  end

  // mode 0 correct, 1 stuck-at-1, 2 stuck-at-0, 3 sparse random, 4 dense random.
  task automatic set_flips(input int s, input int mode);
    int nv;
    nv = 1 << P_N[s];
    for (int v = 0; v < 32; v++) begin
      flip[v] = 1'b0;
      if (v < nv) begin
        case (mode)
          1:       flip[v] = !ref_fn(P_F[s], P_N[s], v);
          2:       flip[v] = ref_fn(P_F[s], P_N[s], v);
          3:       flip[v] = ($urandom_range(0, 3) == 0);
          4:       flip[v] = ($urandom_range(0, 1) == 0);
          default: flip[v] = 1'b0;
        endcase
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int s = 0; s < NI; s++) start_v[s] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < NI; s++) begin
      n_cmp++;
      if ({g_stim[s], g_ff[s], g_err[s], g_busy[s], g_done[s], g_pass[s], g_ffv[s]} !== '0) begin
        n_bad++;
        $display("FAIL reset_state inst=%0d: stim=%h err=%h ff=%h busy=%b done=%b pass=%b vld=%b, want all 0",
                 s, g_stim[s], g_err[s], g_ff[s], g_busy[s], g_done[s], g_pass[s], g_ffv[s]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One sweep on instance s against the current fault table. keep_start
  // leaves start high at the end so the next call runs back to back.
  task automatic test_sweep(input int s, input bit keep_start, input string tag);
    int  n, st, nv, len, exp_err, exp_ff, ign_k, exp_stim;
    bit  exp_ffv, exp_busy, exp_done;
    n       = P_N[s];
    st      = P_S[s];
    nv      = 1 << n;
    len     = nv * (st + 1);
    exp_err = 0;
    exp_ff  = 0;
    exp_ffv = 1'b0;
    for (int i = 0; i < nv; i++) begin
      if (flip[vec_of(i)]) begin
        exp_err++;
        if (!exp_ffv) begin
          exp_ffv = 1'b1;
          exp_ff  = vec_of(i);
        end
      end
    end
    ign_k = keep_start ? -1 : int'($urandom_range(len - 2, 1));

    start_v[s] = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_start) start_v[s] = 1'b0;

    n_cmp++;
    if ({g_err[s], g_ffv[s], g_pass[s]} !== '0) begin
      n_bad++;
      $display("FAIL %s accept_clear inst=%0d: err=%0d vld=%b pass=%b, want 0/0/0",
               tag, s, g_err[s], g_ffv[s], g_pass[s]);
    end

    for (int k = 0; k <= len; k++) begin
      exp_stim = vec_of((k < len) ? k / (st + 1) : nv - 1);
      exp_busy = (k < len);
      exp_done = (k == len);
      n_cmp++;
      if ({g_stim[s], g_busy[s], g_done[s]} !== {16'(exp_stim), exp_busy, exp_done}) begin
        n_bad++;
        $display("FAIL %s timing inst=%0d k=%0d: stim/busy/done=%h/%b/%b, want %h/%b/%b",
                 tag, s, k, g_stim[s], g_busy[s], g_done[s], exp_stim, exp_busy, exp_done);
      end
      if (k == ign_k) start_v[s] = 1'b1;
      else if (!keep_start) start_v[s] = 1'b0;
      if (k < len) begin
        @(posedge clk);
        #1;
      end
    end

    n_cmp++;
    if ({g_err[s], g_pass[s], g_ffv[s], g_ff[s]} !==
        {17'(exp_err), exp_err == 0, exp_ffv, 16'(exp_ff)}) begin
      n_bad++;
      $display("FAIL %s result inst=%0d: err=%0d pass=%b vld=%b ff=%h, want %0d/%b/%b/%h",
               tag, s, g_err[s], g_pass[s], g_ffv[s], g_ff[s], exp_err, exp_err == 0, exp_ffv, exp_ff);
    end

    if (!keep_start) begin
      repeat (3) begin
        @(posedge clk);
        #1;
        n_cmp++;
        if ({g_done[s], g_busy[s], g_stim[s], g_err[s], g_pass[s], g_ffv[s], g_ff[s]} !==
            {2'b00, 16'(vec_of(nv - 1)), 17'(exp_err), exp_err == 0, exp_ffv, 16'(exp_ff)}) begin
          n_bad++;
          $display("FAIL %s hold inst=%0d: done=%b busy=%b stim=%h err=%0d pass=%b vld=%b ff=%h, want 0/0/%h/%0d/%b/%b/%h",
                   tag, s, g_done[s], g_busy[s], g_stim[s], g_err[s], g_pass[s], g_ffv[s], g_ff[s],
                   vec_of(nv - 1), exp_err, exp_err == 0, exp_ffv, exp_ff);
        end
      end
    end
  endtask

  task automatic test_back_to_back(input int s);
    set_flips(s, 4);
    flip[vec_of(1)] = 1'b1;
    test_sweep(s, 1'b1, "b2b_fail");
    set_flips(s, 0);
    test_sweep(s, 1'b0, "b2b_pass");
  endtask

  task automatic test_mid_reset(input int s);
    int len, r;
    len = (1 << P_N[s]) * (P_S[s] + 1);
    r   = int'($urandom_range(len - 1, 2));
    set_flips(s, 3);
    start_v[s] = 1'b1;
    @(posedge clk);
    #1;
    start_v[s] = 1'b0;
    for (int k = 0; k < r; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (g_done[s] !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_rst early_done inst=%0d k=%0d: done=%b, want 0", s, k, g_done[s]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({g_stim[s], g_ff[s], g_err[s], g_busy[s], g_done[s], g_pass[s], g_ffv[s]} !== '0) begin
      n_bad++;
      $display("FAIL mid_rst outputs inst=%0d: stim=%h err=%0d ff=%h busy=%b done=%b pass=%b vld=%b, want all 0",
               s, g_stim[s], g_err[s], g_ff[s], g_busy[s], g_done[s], g_pass[s], g_ffv[s]);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({g_busy[s], g_done[s]} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_rst held inst=%0d: busy=%b done=%b, want 0/0", s, g_busy[s], g_done[s]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_flips(s, 0);
    test_sweep(s, 1'b0, "post_rst");
  endtask

  initial begin
    for (int v = 0; v < 32; v++) flip[v] = 1'b0;
    test_reset();
    for (int s = 0; s < NI; s++) begin
      for (int mode = 0; mode < 5; mode++) begin
        set_flips(s, mode);
        test_sweep(s, 1'b0, "sweep");
      end
    end
    test_back_to_back(0);
    test_back_to_back(3);
    test_mid_reset(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Synthesisable, self-checking exhaustive stimulus engine for an N-input combinational gate under test. It replaces hand-written per-gate sweep benches. On `start` it drives every input vector in turn, waits a programmable settle time, and compares the gate output against a selectable reference function. It then reports the pass/fail result, the mismatch count and the first failing vector. It sits beside any NAND/AND/NOR/OR/XOR gate variant in the gate library and is reused by every gate test.

## Interface
Parameters:
- `N`, 5: number of gate inputs, legal range 1..16.
- `SETTLE`, 2: clock cycles a vector is held before the output is sampled; legal range 1..255.
- `FUNC`, 0: reference function. 0 NAND, 1 AND, 2 NOR, 3 OR, 4 XOR, 5 XNOR. Values 6/7 are illegal.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `stim`  out  N  registered vector driven to the gate under test; bit 0 maps to gate input i1.
- `dut_o`  in  1  gate-under-test output.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse at sweep completion.
- `pass`  out  1  high when the last completed sweep had zero mismatches.
- `err_cnt`  out  N+1  mismatch count for the current or last sweep.
- `first_fail`  out  N  `stim` value at the first mismatch.
- `first_fail_vld`  out  1  `first_fail` holds a valid vector.

## Operation
- **Reset values:** every output is 0, the FSM is in IDLE and the internal index is 0.
- **FSM states:** IDLE, APPLY, CHECK.
- **IDLE:**
  - `start`=1 clears `err_cnt`, `pass`, `first_fail` and `first_fail_vld`.
  - It sets index=0, `stim`=vec(0), settle counter=SETTLE, `busy`=1, and moves to APPLY.
- **APPLY:** decrements the settle counter each cycle and moves to CHECK when it reaches 1.
- **CHECK:** samples `dut_o` and compares it with ref(`stim`) for the selected FUNC, reduced over all N bits of `stim`.
  - On a mismatch, `err_cnt` increments.
  - On the first mismatch of the sweep, `stim` is captured into `first_fail` and `first_fail_vld` is set.
  - If index = 2^N−1: go to IDLE, pulse `done`, drop `busy`, and set `pass` = (final `err_cnt`, including this check, == 0).
  - Otherwise: index increments, `stim`=vec(index+1), the settle counter reloads and the FSM returns to APPLY.
- **Vector mapping:** vec(i)=i (binary order) unless reordered by the configuration below.
- **Counter width:** `err_cnt` is N+1 bits, so its maximum value of 2^N cannot overflow and no saturation logic is required.
- **Start during a sweep:** `start` while `busy` is ignored; it neither restarts nor queues a sweep.
- **Hold after sweep:** `stim` holds the last vector after the sweep. `pass`, `err_cnt` and `first_fail*` hold until the next accepted `start`.
- **Reset mid-sweep:** an `rst_n` assertion returns every output to its reset value immediately, with no `done` pulse.
- **N=1:** the sweep has 2 vectors. XOR/XNOR reduce to buffer/inverter.

## Timing
- **Stimulus:** `stim` changes on the edge after `start` is sampled, then every SETTLE+1 cycles. Each vector is stable for exactly SETTLE+1 cycles.
- **Sampling:** `dut_o` is sampled at the CHECK edge, SETTLE cycles after `stim` last changed.
- **Latency:** `done` rises 2^N·(SETTLE+1) cycles after the `start` sampling edge and lasts one cycle.
- **Busy:** `busy` falls on the same edge that `done` rises.
- **Back-to-back sweeps:** a `start` held high continuously begins a new sweep on the cycle after `done`.

## Configuration
- **`GATE_SWEEP_GRAY_EN` defined:** vec(i)=i^(i>>1), so consecutive vectors differ in exactly one bit (hazard-sensitive sweep).
  - `first_fail` reports the Gray-coded `stim` value, not the index.
  - Latency and the total vector set are unchanged.
- **Not defined:** binary order, vec(i)=i.

## Test plan
- **Correct NAND, binary:** N=2, SETTLE=1, FUNC=0, `dut_o`=~&`stim`. Pulse `start` → `stim` sequence 00,01,10,11, each held 2 cycles. `done` rises 8 cycles after start; `pass`=1, `err_cnt`=0, `first_fail_vld`=0.
- **Stuck-at-1 output:** N=2, FUNC=0, `dut_o`=1 → `err_cnt`=1, `first_fail`=2'b11, `first_fail_vld`=1, `pass`=0.
- **Gray order, stuck-at-0 output:** `GATE_SWEEP_GRAY_EN` defined, N=3, SETTLE=2, FUNC=0, `dut_o`=0 → `stim` order 000,001,011,010,110,111,101,100. `err_cnt`=7, `first_fail`=3'b000, `done` at cycle 24.
- **Correct XOR, N=5:** N=5, SETTLE=3, FUNC=4, correct XOR model → 32 vectors, `done` at cycle 128, `pass`=1. A `start` pulse at cycle 40 is ignored and `err_cnt` is unchanged.
- **Reset mid-sweep:** N=3, assert `rst_n`=0 at cycle 10 → all outputs 0 immediately, no `done`. A new `start` after release completes normally with a correct model.
- **Sticky results:** run a failing sweep, then a passing sweep → the second `start` clears `err_cnt`/`first_fail_vld` on the accept edge. The final `pass`=1.
